// File: rtl/core_pkg.sv
// Shared types and sizing for the register-pending hazard scoreboard.
package core_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int MAX_LAT  = 15;
  localparam int LAT_W    = $clog2(MAX_LAT + 1);

  // One tracked register: pending write, variable-latency marker, fixed countdown.
  typedef struct packed {
    logic             pending;
    logic             is_var;
    logic [LAT_W-1:0] cnt;
  } sb_entry_t;

  // Saturate a requested latency to the largest countdown we support.
  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (int'(lat) > MAX_LAT) begin
      return LAT_W'(MAX_LAT);
    end
    return lat;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// Scoreboard state for one architectural register: set on issue, count down
// (fixed latency) or wait for a completion (variable latency), cleared by flush.
// Optional bypass awareness: SCOREBOARD_FWD_EN hides a fixed entry from RAW checks
// in its last countdown cycle, since the result can be forwarded next cycle.
module sb_entry
  import core_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [LAT_W-1:0] lat_i,
  input  logic             busywait_i,
  input  logic             complete_i,
  input  logic             flush_i,
  output logic             pending_o,
  output logic             raw_vis_o
);

  sb_entry_t entry;

  // Flush wins over everything; a new issue can never coincide with a live entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      entry <= '0;
    end else if (flush_i) begin
      entry <= '0;
    end else if (set_i) begin
      entry.pending <= 1'b1;
      entry.is_var  <= (lat_i == '0);
      entry.cnt     <= clamp_lat(lat_i);
    end else if (entry.pending && entry.is_var) begin
      if (complete_i) begin
        entry <= '0;
      end
    end else if (entry.pending && !busywait_i) begin
      if (entry.cnt == LAT_W'(1)) begin
        entry <= '0;
      end else begin
        entry.cnt <= entry.cnt - LAT_W'(1);
      end
    end
  end

  assign pending_o = entry.pending;

`ifdef SCOREBOARD_FWD_EN
  assign raw_vis_o = entry.pending & ~(~entry.is_var & (entry.cnt == LAT_W'(1)));
`else
  assign raw_vis_o = entry.pending;
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-pending scoreboard at the ID/EX boundary. Detects RAW/WAW hazards
// against in-flight writes, records accepted issues, and cancels the previous
// cycle's issue on a branch flush. SCOREBOARD_FWD_EN (in sb_entry) relaxes RAW
// checks for fixed results about to reach the bypass network.
module hazard_scoreboard
  import core_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                busywait_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic                issue_wb_en_i,
  input  logic [REG_W-1:0]    issue_rd_i,
  input  logic [LAT_W-1:0]    issue_lat_i,
  input  logic [REG_W-1:0]    issue_rs1_i,
  input  logic                issue_rs1_used_i,
  input  logic [REG_W-1:0]    issue_rs2_i,
  input  logic                issue_rs2_used_i,
  input  logic                complete_valid_i,
  input  logic [REG_W-1:0]    complete_rd_i,
  output logic                stall_o,
  output logic                issue_accept_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                busy_o
);

  logic [NUM_REGS-1:0] pend_vec;
  logic [NUM_REGS-1:0] raw_vis;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                creates;
  logic                last_valid;
  logic [REG_W-1:0]    last_rd;

  // Hazard compare and issue decision for the instruction sitting in ID.
  always_comb begin
    raw1           = 1'b0;
    raw2           = 1'b0;
    waw            = 1'b0;
    raw1           = issue_rs1_used_i & (issue_rs1_i != '0) & raw_vis[issue_rs1_i];
    raw2           = issue_rs2_used_i & (issue_rs2_i != '0) & raw_vis[issue_rs2_i];
    waw            = issue_wb_en_i & (issue_rd_i != '0) & pend_vec[issue_rd_i];
    stall_o        = issue_valid_i & (raw1 | raw2 | waw);
    issue_accept_o = issue_valid_i & ~stall_o & ~busywait_i & ~flush_i;
    creates        = issue_accept_o & issue_wb_en_i & (issue_rd_i != '0);
  end

  // Remember which entry the previous cycle created so a flush can cancel it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_valid <= 1'b0;
      last_rd    <= '0;
    end else begin
      last_valid <= creates;
      last_rd    <= issue_rd_i;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_zero
      assign pend_vec[g] = 1'b0;
      assign raw_vis[g]  = 1'b0;
    end else begin : g_track
      sb_entry u_entry (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (creates & (issue_rd_i == REG_W'(g))),
        .lat_i      (issue_lat_i),
        .busywait_i (busywait_i),
        .complete_i (complete_valid_i & (complete_rd_i == REG_W'(g))),
        .flush_i    (flush_i & last_valid & (last_rd == REG_W'(g))),
        .pending_o  (pend_vec[g]),
        .raw_vis_o  (raw_vis[g])
      );
    end
  end

  assign pending_o = pend_vec;
  assign busy_o    = |pend_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        busywait_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_wb_en_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [3:0]  issue_lat_i = '0;
  logic [4:0]  issue_rs1_i = '0;
  logic        issue_rs1_used_i = 1'b0;
  logic [4:0]  issue_rs2_i = '0;
  logic        issue_rs2_used_i = 1'b0;
  logic        complete_valid_i = 1'b0;
  logic [4:0]  complete_rd_i = '0;
  logic        stall_o;
  logic        issue_accept_o;
  logic [31:0] pending_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

`ifdef SCOREBOARD_FWD_EN
  localparam int RAW_STALL_CYCLES = 2;
`else
  localparam int RAW_STALL_CYCLES = 3;
`endif

  hazard_scoreboard dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .busywait_i       (busywait_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_wb_en_i    (issue_wb_en_i),
    .issue_rd_i       (issue_rd_i),
    .issue_lat_i      (issue_lat_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_rs1_used_i (issue_rs1_used_i),
    .issue_rs2_i      (issue_rs2_i),
    .issue_rs2_used_i (issue_rs2_used_i),
    .complete_valid_i (complete_valid_i),
    .complete_rd_i    (complete_rd_i),
    .stall_o          (stall_o),
    .issue_accept_o   (issue_accept_o),
    .pending_o        (pending_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wb_en, input logic [4:0] rd,
                               input logic [3:0] lat, input logic [4:0] rs1, input logic rs1_used,
                               input logic [4:0] rs2, input logic rs2_used);
    issue_valid_i    = valid;
    issue_wb_en_i    = wb_en;
    issue_rd_i       = rd;
    issue_lat_i      = lat;
    issue_rs1_i      = rs1;
    issue_rs1_used_i = rs1_used;
    issue_rs2_i      = rs2;
    issue_rs2_used_i = rs2_used;
  endtask

  task automatic idleIssue();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2 rst_i = 1'b0;
    #1;
    checkOutput("rst_pending", pending_o, 32'h0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'h0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();

    // Reset while x5 is mid-countdown
    applyStimulus(1'b1, 1'b1, 5'd5, 4'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput("t1_accept", {31'b0, issue_accept_o}, 32'h1);
    tick();
    idleIssue();
    tick();
    checkOutput("t1_pend_before", pending_o, 32'h0000_0020);
    checkOutput("t1_busy_before", {31'b0, busy_o}, 32'h1);
    rst_i = 1'b0;
    #1;
    checkOutput("t1_pend_rst", pending_o, 32'h0);
    checkOutput("t1_busy_rst", {31'b0, busy_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 checkOutput("t1_stall_rst", {31'b0, stall_o}, 32'h0);
    idleIssue();
    #1 rst_i = 1'b1;
    tick();

    // RAW follower on fixed latency 3
    applyStimulus(1'b1, 1'b1, 5'd5, 4'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput("t2_issue", {31'b0, issue_accept_o}, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 5'd5, 1'b1, 5'd0, 1'b0);
    for (int c = 0; c < RAW_STALL_CYCLES; c++) begin
      #1;
      checkOutput("t2_stall", {31'b0, stall_o}, 32'h1);
      checkOutput("t2_noacc", {31'b0, issue_accept_o}, 32'h0);
      tick();
    end
    #1;
    checkOutput("t2_go_stall", {31'b0, stall_o}, 32'h0);
    checkOutput("t2_go_acc", {31'b0, issue_accept_o}, 32'h1);
    tick();
    idleIssue();
    checkOutput("t2_clear", pending_o, 32'h0);

    // Variable latency x7, ignored completions, completion during busywait
    applyStimulus(1'b1, 1'b1, 5'd7, 4'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput("t3_accept", {31'b0, issue_accept_o}, 32'h1);
    tick();
    idleIssue();
    for (int c = 0; c < 10; c++) begin
      complete_valid_i = (c == 4) || (c == 6);
      complete_rd_i    = (c == 4) ? 5'd8 : 5'd0;
      tick();
    end
    complete_valid_i = 1'b0;
    checkOutput("t3_hold", pending_o, 32'h0000_0080);
    busywait_i = 1'b1;
    complete_valid_i = 1'b1;
    complete_rd_i = 5'd7;
    applyStimulus(1'b1, 1'b1, 5'd10, 4'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("t3_bw_noacc", {31'b0, issue_accept_o}, 32'h0);
    checkOutput("t3_bw_nostall", {31'b0, stall_o}, 32'h0);
    tick();
    busywait_i = 1'b0;
    complete_valid_i = 1'b0;
    idleIssue();
    checkOutput("t3_clear", pending_o, 32'h0);

    // Flush cancels x9 only; older x4 keeps counting
    applyStimulus(1'b1, 1'b1, 5'd4, 4'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 4'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput("t4_acc_x9", {31'b0, issue_accept_o}, 32'h1);
    tick();
    idleIssue();
    checkOutput("t4_both", pending_o, 32'h0000_0210);
    flush_i = 1'b1;
    tick();
    checkOutput("t4_flushed", pending_o, 32'h0000_0010);
    tick();
    flush_i = 1'b0;
    checkOutput("t4_stale_flush", pending_o, 32'h0000_0010);
    tick();
    checkOutput("t4_x4_cnt", pending_o, 32'h0000_0010);
    tick();
    checkOutput("t4_x4_done", pending_o, 32'h0);

    // x0 never tracked; WAW and rs2 RAW on x3
    applyStimulus(1'b1, 1'b1, 5'd0, 4'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput("t5_x0_acc", {31'b0, issue_accept_o}, 32'h1);
    tick();
    checkOutput("t5_x0_pend", pending_o, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 checkOutput("t5_x0_stall", {31'b0, stall_o}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 4'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 4'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    checkOutput("t5_waw", {31'b0, stall_o}, 32'h1);
    checkOutput("t5_waw_acc", {31'b0, issue_accept_o}, 32'h0);
    applyStimulus(1'b1, 1'b0, 5'd0, 4'd0, 5'd1, 1'b1, 5'd3, 1'b1);
    #1 checkOutput("t5_raw_rs2", {31'b0, stall_o}, 32'h1);
    idleIssue();
    tick();
    tick();
    tick();
    checkOutput("t5_clear", pending_o, 32'h0);

    // Busywait freezes fixed countdown of x6
    applyStimulus(1'b1, 1'b1, 5'd6, 4'd2, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    idleIssue();
    tick();
    busywait_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("t6_frozen", pending_o, 32'h0000_0040);
    busywait_i = 1'b0;
    tick();
    checkOutput("t6_clear", pending_o, 32'h0);
    checkOutput("t6_busy", {31'b0, busy_o}, 32'h0);

    // Latency 1 is pending for exactly one cycle
    applyStimulus(1'b1, 1'b1, 5'd11, 4'd1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    idleIssue();
    checkOutput("t7_lat1_on", pending_o, 32'h0000_0800);
    tick();
    checkOutput("t7_lat1_off", pending_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
